kbd_tx: RTL and testbench

Memory-mapped PS/2 host-to-device transmitter, the send-side companion of the keyboard receive peripheral. It sends one command byte to the keyboard (LED set, typematic rate, reset, and similar) using the host-initiated PS/2 frame, then reports ACK/NACK/timeout status on the CPU data bus. It sits beside the receive peripheral on the same PS2_CLK/PS2_DAT pins. The top level turns the pull outputs into open-drain drivers.

---
 rtl/kbd_tx_pkg.sv | 39 +++
 rtl/kbd_tx_ps2_host_tx.sv | 172 +++++++++++++++++
 rtl/kbd_tx.sv | 110 +++++++++++
 tb/tb_kbd_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_tx_pkg.sv
// ============================================================================
// Module      : kbd_tx_pkg
// Description : Shared register map, STATUS bit indices and FSM encoding for
//               the PS/2 host-to-device transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_tx_pkg;

    localparam int c_data_w       = 32;
    localparam int c_addr_sel_bit = 2;

    // Register offsets as seen on addr[c_addr_sel_bit]
    localparam logic c_reg_data   = 1'b0;
    localparam logic c_reg_status = 1'b1;

    localparam int c_st_busy    = 0;
    localparam int c_st_ack_ok  = 1;
    localparam int c_st_nack    = 2;
    localparam int c_st_timeout = 3;
    localparam int c_st_drop    = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } tx_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_tx_ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device frame engine: pin synchronizers, frame
//               FSM, inhibit/timeout counter and open-drain pull controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
    import kbd_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       ack,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_pull,
    output logic       ps2_dat_pull
);

    localparam int c_cnt_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    tx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]         r_bit_cnt, w_bit_nxt;
    logic [2:0]         r_clk_sync;
    logic [1:0]         r_dat_sync;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic               r_clk_pull, w_clk_pull_nxt;
    logic               r_dat_pull, w_dat_pull_nxt;
    logic               w_fall, w_counting, w_done, w_ack, w_timeout, w_load;

    // [1] is the synced level, [2] its previous value
    assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_load = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_clk_pull <= 1'b0;
            r_dat_pull <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
            r_clk_pull <= w_clk_pull_nxt;
            r_dat_pull <= w_dat_pull_nxt;
            if (w_load) begin
                r_byte   <= tx_data;
                r_parity <= odd_parity(tx_data);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_clk_pull_nxt = r_clk_pull;
        w_dat_pull_nxt = r_dat_pull;
        w_done         = 1'b0;
        w_ack          = 1'b0;
        w_timeout      = 1'b0;
        w_counting     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_pull_nxt = 1'b0;
                w_dat_pull_nxt = 1'b0;
                if (start) begin
                    w_state_nxt    = S_INHIBIT;
                    w_cnt_nxt      = '0;
                    w_clk_pull_nxt = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == c_inh_last) begin
                    w_state_nxt    = S_REQ;
                    w_cnt_nxt      = '0;
                    w_bit_nxt      = '0;
                    w_clk_pull_nxt = 1'b0;
                    w_dat_pull_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_REQ: begin
                w_counting  = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_counting = 1'b1;
                if (w_fall) begin
                    w_bit_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt < 4'd8) begin
                        w_dat_pull_nxt = ~r_byte[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_dat_pull_nxt = ~r_parity;
                    end else begin
                        w_dat_pull_nxt = 1'b0;
                        w_state_nxt    = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_counting = 1'b1;
                if (w_fall) begin
                    w_done      = 1'b1;
                    w_ack       = ~r_dat_sync[1];
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_counting = 1'b1;
                if (r_clk_sync[1] && r_dat_sync[1]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_clk_pull_nxt = 1'b0;
                w_dat_pull_nxt = 1'b0;
            end
        endcase

        // Device-clock watchdog overrides whatever the state wanted to do
        if (w_counting) begin
            if (w_fall) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == c_to_last) begin
                w_timeout      = 1'b1;
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
                w_clk_pull_nxt = 1'b0;
                w_dat_pull_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign tx_byte      = r_byte;
    assign busy         = (r_state != S_IDLE);
    assign done         = w_done;
    assign ack          = w_ack;
    assign timeout      = w_timeout;
    assign ps2_clk_pull = r_clk_pull;
    assign ps2_dat_pull = r_dat_pull;

endmodule

`default_nettype wire

// File: rtl/kbd_tx.sv
// ============================================================================
// Module      : kbd_tx
// Description : Memory-mapped PS/2 command transmitter: bus decode, sticky
//               status flags and registered read data around ps2_host_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_tx
    import kbd_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                rw,
    input  logic [c_data_w-1:0] addr,
    output logic [c_data_w-1:0] rdata,
    input  logic [c_data_w-1:0] wdata,
    input  logic                ps2_clk_in,
    input  logic                ps2_dat_in,
    output logic                ps2_clk_pull,
    output logic                ps2_dat_pull,
    output logic                tx_busy
);

    logic [c_data_w-1:0] r_rdata;
    logic                r_ack_ok, r_nack, r_timeout, r_drop;
    logic [c_data_w-1:0] w_status;
    logic [7:0]          w_byte;
    logic                w_busy, w_done, w_ack, w_to;
    logic                w_sel_status, w_wr_data, w_start, w_rd;
    logic                w_unused_bits;

    assign w_sel_status  = (addr[c_addr_sel_bit] == c_reg_status);
    assign w_wr_data     = ena && rw && !w_sel_status;
    assign w_start       = w_wr_data && !w_busy;
    assign w_rd          = ena && !rw;
    assign w_unused_bits = ^{addr[c_data_w-1:c_addr_sel_bit+1], addr[c_addr_sel_bit-1:0],
                             wdata[c_data_w-1:8]};

    always_comb begin
        w_status               = '0;
        w_status[c_st_busy]    = w_busy;
        w_status[c_st_ack_ok]  = r_ack_ok;
        w_status[c_st_nack]    = r_nack;
        w_status[c_st_timeout] = r_timeout;
        w_status[c_st_drop]    = r_drop;
    end

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_host (
        .clk          (clk),
        .rst          (rst),
        .start        (w_start),
        .tx_data      (wdata[7:0]),
        .tx_byte      (w_byte),
        .busy         (w_busy),
        .done         (w_done),
        .ack          (w_ack),
        .timeout      (w_to),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .ps2_clk_pull (ps2_clk_pull),
        .ps2_dat_pull (ps2_dat_pull)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata   <= '0;
            r_ack_ok  <= 1'b0;
            r_nack    <= 1'b0;
            r_timeout <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            if (w_start) begin
                r_ack_ok  <= 1'b0;
                r_nack    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_done) begin
                r_ack_ok <= w_ack;
                r_nack   <= ~w_ack;
            end
            if (w_to) begin
                r_timeout <= 1'b1;
            end
            // A drop landing on the same cycle as a STATUS read stays visible
            if (w_rd && w_sel_status) begin
                r_drop <= 1'b0;
            end
            if (w_wr_data && w_busy) begin
                r_drop <= 1'b1;
            end
            if (w_rd) begin
                r_rdata <= w_sel_status ? w_status : {{(c_data_w-8){1'b0}}, w_byte};
            end
        end
    end

    assign rdata   = r_rdata;
    assign tx_busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_kbd_tx.sv
// ============================================================================
// Module      : tb_kbd_tx
// Description : Self-checking bench for kbd_tx with a behavioural PS/2
//               keyboard model and a flag-level status model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_tx;

    localparam int c_inh = 40;
    localparam int c_to  = 300;
    localparam int c_h   = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        rw  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ps2_clk_pull, ps2_dat_pull, tx_busy;
    logic        dev_clk = 1'b1;
    logic        dev_dat = 1'b1;
    wire         ps2_clk_in = dev_clk & ~ps2_clk_pull;
    wire         ps2_dat_in = dev_dat & ~ps2_dat_pull;

    int n_checks = 0;
    int n_fail   = 0;

    // Status model
    bit m_busy, m_ack, m_nack, m_to, m_drop;

    kbd_tx #(
        .INHIBIT_CYCLES (c_inh),
        .TIMEOUT_CYCLES (c_to)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rw           (rw),
        .addr         (addr),
        .rdata        (rdata),
        .wdata        (wdata),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .ps2_clk_pull (ps2_clk_pull),
        .ps2_dat_pull (ps2_dat_pull),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {27'b0, m_drop, m_to, m_nack, m_ack, m_busy};
    endfunction

    task automatic bus_write_data(input logic [7:0] b);
        @(negedge clk);
        ena = 1'b1; rw = 1'b1; addr = 32'h0; wdata = {$urandom} & 32'hFFFF_FF00 | {24'b0, b};
        @(negedge clk);
        ena = 1'b0; rw = 1'b0;
        if (m_busy) m_drop = 1'b1;
        else begin
            m_busy = 1'b1; m_ack = 1'b0; m_nack = 1'b0; m_to = 1'b0;
        end
    endtask

    task automatic bus_read(input bit sel_status, output logic [31:0] v);
        @(negedge clk);
        ena = 1'b1; rw = 1'b0; addr = sel_status ? 32'h4 : 32'h0;
        @(negedge clk);
        ena = 1'b0;
        v = rdata;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        bus_read(1'b1, v);
        chk(tag, v, m_status());
        m_drop = 1'b0;
    endtask

    // Keyboard model: measures the inhibit, then clocks n_falls falling edges,
    // sampling the line on each rising edge. smp[0]=start .. smp[10]=stop.
    task automatic device_frame(input int n_falls, input bit leave_low, input bit do_ack,
                                output logic [10:0] smp, output int inh_len);
        int guard = 0;
        smp = '1;
        inh_len = 0;
        while (!ps2_clk_pull && guard < 200) begin @(negedge clk); guard++; end
        while (ps2_clk_pull && inh_len < c_inh * 4) begin @(negedge clk); inh_len++; end
        repeat (c_h) @(negedge clk);
        smp[0] = ps2_dat_in;
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk = 1'b0;
            repeat (c_h) @(negedge clk);
            if (leave_low && k == n_falls) return;
            dev_clk = 1'b1;
            if (k <= 10) smp[k] = ps2_dat_in;
            if (k == 10 && do_ack) dev_dat = 1'b0;
            repeat (c_h) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_not_busy(input int bound, output int cyc);
        cyc = 0;
        while (tx_busy && cyc < bound) begin @(negedge clk); cyc++; end
        if (tx_busy) chk("busy_wait_expired", 32'(tx_busy), 32'h0);
    endtask

    // side: 0 none, 1 second write while busy, 2 DATA read checks
    task automatic run_frame(input logic [7:0] b, input bit do_ack, input int side, input string tag);
        logic [10:0] smp;
        logic [31:0] v;
        int inh, cyc;
        bus_write_data(b);
        fork
            device_frame(11, 1'b0, do_ack, smp, inh);
            begin
                if (side == 1) begin
                    repeat (5) @(negedge clk);
                    bus_write_data(8'hF4);
                end else if (side == 2) begin
                    bus_read(1'b0, v);
                    chk({tag, "_data_read"}, v, {24'b0, b});
                    @(negedge clk);
                    addr = 32'h4; rw = 1'b0; ena = 1'b0;
                    @(negedge clk);
                    chk({tag, "_rdata_hold"}, rdata, {24'b0, b});
                end
            end
        join
        chk({tag, "_inhibit_len"}, 32'(inh), 32'(c_inh));
        chk({tag, "_start"}, 32'(smp[0]), 32'h0);
        chk({tag, "_bits"}, {24'b0, smp[8:1]}, {24'b0, b});
        chk({tag, "_parity"}, 32'(smp[9]), ($countones(b) % 2 == 0) ? 32'h1 : 32'h0);
        chk({tag, "_stop"}, 32'(smp[10]), 32'h1);
        wait_not_busy(200, cyc);
        m_busy = 1'b0;
        if (do_ack) m_ack = 1'b1; else m_nack = 1'b1;
        check_status({tag, "_status"});
    endtask

    initial begin
        logic [10:0] smp;
        logic [31:0] v;
        int inh, cyc;

        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_pulls", {30'b0, ps2_clk_pull, ps2_dat_pull}, 32'h0);
        chk("reset_busy", 32'(tx_busy), 32'h0);
        rst = 1'b0;
        check_status("reset_status");

        run_frame(8'hED, 1'b1, 0, "ed_ack");
        run_frame(8'h00, 1'b0, 0, "00_nack");

        // Device stops clocking after fall 4
        bus_write_data(8'hFF);
        device_frame(4, 1'b0, 1'b0, smp, inh);
        wait_not_busy(c_to + 100, cyc);
        chk("to_window", 32'((cyc >= c_to - 2 * c_h) && (cyc <= c_to)), 32'h1);
        chk("to_pulls", {30'b0, ps2_clk_pull, ps2_dat_pull}, 32'h0);
        m_busy = 1'b0; m_to = 1'b1;
        check_status("to_status");

        run_frame(8'h12, 1'b1, 1, "drop");
        check_status("drop_cleared");

        // Reset during SEND right after fall 5
        bus_write_data(8'hED);
        device_frame(5, 1'b1, 1'b0, smp, inh);
        repeat (4) @(negedge clk);
        chk("pre_rst_dat_pull", 32'(ps2_dat_pull), 32'h1);
        #2 rst = 1'b1;
        #1 chk("rst_pulls", {30'b0, ps2_clk_pull, ps2_dat_pull}, 32'h0);
        chk("rst_busy", 32'(tx_busy), 32'h0);
        dev_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_ack = 1'b0; m_nack = 1'b0; m_to = 1'b0; m_drop = 1'b0;
        check_status("rst_status");
        run_frame(8'hED, 1'b1, 0, "post_rst");

        run_frame(8'hAB, 1'b1, 2, "ab");

        for (int i = 0; i < 8; i++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", i));
        end

        bus_read(1'b0, v);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
